// File: rtl/neuron_ctrl_if.sv
// neuron_ctrl_if: bundle between the readout FSMs / control module and the neuron-control arbiter
// Signals: req and per-requester command bits in; one-hot grant, owner_idx and busy out;
//   routed command outputs toward the control module; neuron_idle/spi_valid from the control
//   module with owner-only fan-back; sticky watchdog error reporting with err_clear.
interface neuron_ctrl_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [2:0]         owner_idx;
    logic               busy;
    logic [NUM_REQ-1:0] r_spi_read_trigger;
    logic [NUM_REQ-1:0] r_neuron_reset_trigger;
    logic [NUM_REQ-1:0] r_turn_off_inference;
    logic [NUM_REQ-1:0] r_ext_inference_enable;
    logic [NUM_REQ-1:0] r_reg_reset;
    logic               spi_read_trigger;
    logic               neuron_reset_trigger;
    logic               turn_off_inference;
    logic               ext_inference_enable;
    logic               reg_reset;
    logic               neuron_idle;
    logic               spi_valid;
    logic [NUM_REQ-1:0] g_neuron_idle;
    logic [NUM_REQ-1:0] g_spi_valid;
    logic               timeout_err;
    logic [2:0]         timeout_idx;
    logic               err_clear;

    modport master (
        output req, r_spi_read_trigger, r_neuron_reset_trigger, r_turn_off_inference,
               r_ext_inference_enable, r_reg_reset, neuron_idle, spi_valid, err_clear,
        input  grant, owner_idx, busy, spi_read_trigger, neuron_reset_trigger,
               turn_off_inference, ext_inference_enable, reg_reset, g_neuron_idle,
               g_spi_valid, timeout_err, timeout_idx
    );

    modport slave (
        input  req, r_spi_read_trigger, r_neuron_reset_trigger, r_turn_off_inference,
               r_ext_inference_enable, r_reg_reset, neuron_idle, spi_valid, err_clear,
        output grant, owner_idx, busy, spi_read_trigger, neuron_reset_trigger,
               turn_off_inference, ext_inference_enable, reg_reset, g_neuron_idle,
               g_spi_valid, timeout_err, timeout_idx
    );
endinterface

// File: rtl/neuron_ctrl_arbiter.sv
// neuron_ctrl_arbiter: round-robin sharing of the neuron-control interface between readout FSMs
// Ports: clk; rst (synchronous, active-high); bus (neuron_ctrl_if.slave) carrying requests,
//   per-requester command bits, the registered grant/owner_idx, busy, the registered command
//   outputs to the control module, owner-only neuron_idle/spi_valid fan-back and watchdog errors.
module neuron_ctrl_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_W      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF,
    parameter int unsigned GUARD_CYCLES   = 4
) (
    input logic          clk,
    input logic          rst,
    neuron_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;
    state_t               state, state_n;
    logic [NUM_REQ-1:0]   mask, mask_n, elig, elig_hi, grant_n;
    logic [2:0]           ptr, ptr_n, pick, pick_lo, pick_hi, owner_n, tidx_n;
    logic [TIMEOUT_W-1:0] wd, wd_n, wd_inc;
    logic [3:0]           gcnt, gcnt_n;
    logic [4:0]           own_cmd, cmd_n;
    logic                 own_req, own_trig, rel, tmo, err_n;

    // A revoked requester stays masked until it drops req.
    assign elig = bus.req & ~mask;
    // Requesters at or above the pointer win; otherwise wrap to the lowest one below it.
    assign elig_hi = elig & ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));

    always_comb begin
        pick_lo = '0;
        pick_hi = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (elig[i]) pick_lo = 3'(i);
            if (elig_hi[i]) pick_hi = 3'(i);
        end
        pick = (|elig_hi) ? pick_hi : pick_lo;
    end

    // grant is one-hot while owned, so masking with it selects the owner's bits.
    assign own_req  = |(bus.req & bus.grant);
    assign own_cmd  = {|(bus.r_spi_read_trigger & bus.grant), |(bus.r_neuron_reset_trigger & bus.grant),
                       |(bus.r_turn_off_inference & bus.grant), |(bus.r_ext_inference_enable & bus.grant),
                       |(bus.r_reg_reset & bus.grant)};
    assign own_trig = own_cmd[4] | own_cmd[3];
    assign wd_inc   = wd + TIMEOUT_W'(1);
    // Release wins over a coincident timeout; a trigger this cycle also resets the watchdog.
    assign rel = (state == GRANT) && !own_req;
    assign tmo = (state == GRANT) && own_req && !own_trig && (TIMEOUT_CYCLES != 0) &&
                 (wd_inc == TIMEOUT_W'(TIMEOUT_CYCLES));

    assign bus.g_neuron_idle = bus.grant & {NUM_REQ{bus.neuron_idle}};
    assign bus.g_spi_valid   = bus.grant & {NUM_REQ{bus.spi_valid}};
    assign bus.busy          = state != IDLE;

    always_comb begin
        state_n = state;
        grant_n = bus.grant;
        owner_n = bus.owner_idx;
        ptr_n   = ptr;
        wd_n    = wd;
        gcnt_n  = gcnt;
        cmd_n   = '0;
        mask_n  = (mask & bus.req) | (tmo ? bus.grant : '0);
        err_n   = !bus.err_clear && (bus.timeout_err || tmo);
        tidx_n  = tmo ? bus.owner_idx : bus.timeout_idx;
        case (state)
            IDLE: if (|elig) begin
                state_n = GRANT;
                grant_n = NUM_REQ'(1) << pick;
                owner_n = pick;
                wd_n    = '0;
            end
            GRANT: if (rel || tmo) begin
                state_n = DRAIN;
                grant_n = '0;
                ptr_n   = (bus.owner_idx == 3'(NUM_REQ - 1)) ? 3'd0 : bus.owner_idx + 3'd1;
                gcnt_n  = '0;
            end else begin
                wd_n  = own_trig ? '0 : wd_inc;
                cmd_n = own_cmd;
            end
            DRAIN: begin
                gcnt_n = gcnt + 4'(gcnt != 4'hF);
                if (gcnt >= 4'(GUARD_CYCLES - 1) && bus.neuron_idle) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            mask            <= '0;
            wd              <= '0;
            gcnt            <= '0;
            bus.grant       <= '0;
            bus.owner_idx   <= '0;
            bus.timeout_err <= 1'b0;
            bus.timeout_idx <= '0;
            {bus.spi_read_trigger, bus.neuron_reset_trigger, bus.turn_off_inference,
             bus.ext_inference_enable, bus.reg_reset} <= '0;
        end else begin
            state           <= state_n;
            ptr             <= ptr_n;
            mask            <= mask_n;
            wd              <= wd_n;
            gcnt            <= gcnt_n;
            bus.grant       <= grant_n;
            bus.owner_idx   <= owner_n;
            bus.timeout_err <= err_n;
            bus.timeout_idx <= tidx_n;
            {bus.spi_read_trigger, bus.neuron_reset_trigger, bus.turn_off_inference,
             bus.ext_inference_enable, bus.reg_reset} <= cmd_n;
        end
    end
endmodule

// File: tb/tb_neuron_ctrl_arbiter.sv
// tb_neuron_ctrl_arbiter: directed bench with a cycle model of the arbitration rules
module tb_neuron_ctrl_arbiter;
    localparam int N  = 4;
    localparam int TO = 20;
    localparam int GC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_ctrl_if #(.NUM_REQ(N)) bus ();
    neuron_ctrl_arbiter #(.NUM_REQ(N), .TIMEOUT_W(16), .TIMEOUT_CYCLES(TO), .GUARD_CYCLES(GC))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    int       m_owner = -1;
    int       m_last  = 0;
    int       m_ptr   = 0;
    int       m_wd    = 0;
    int       m_dcnt  = 0;
    int       m_tidx  = 0;
    bit       m_drain = 1'b0;
    bit       m_err   = 1'b0;
    bit [N-1:0] m_blk = '0;
    bit [4:0] m_cmd   = '0;
    bit       chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural view: who owns the bus, how long the drain has run, who is locked out.
    task automatic model_step();
        int pick;
        int c;
        bit to;
        bit trig;
        bit rel;
        if (rst) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_wd = 0; m_dcnt = 0; m_tidx = 0;
            m_drain = 0; m_err = 0; m_blk = '0; m_cmd = '0; chk_en = 1;
            return;
        end
        pick = -1;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (pick < 0 && bus.req[c] && !m_blk[c]) pick = c;
        end
        m_blk = m_blk & bus.req;
        m_cmd = '0;
        to = 0;
        if (m_owner >= 0) begin
            rel  = !bus.req[m_owner];
            trig = bus.r_spi_read_trigger[m_owner] | bus.r_neuron_reset_trigger[m_owner];
            to   = !rel && !trig && (m_wd + 1 == TO);
            if (rel || to) begin
                if (to) begin
                    m_tidx = m_owner;
                    m_blk[m_owner] = 1'b1;
                end
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
                m_drain = 1;
                m_dcnt = 0;
            end else begin
                m_wd = trig ? 0 : m_wd + 1;
                m_cmd = {bus.r_spi_read_trigger[m_owner], bus.r_neuron_reset_trigger[m_owner],
                         bus.r_turn_off_inference[m_owner], bus.r_ext_inference_enable[m_owner],
                         bus.r_reg_reset[m_owner]};
            end
        end else if (m_drain) begin
            m_dcnt++;
            if (m_dcnt >= GC && bus.neuron_idle) m_drain = 0;
        end else if (pick >= 0) begin
            m_owner = pick;
            m_last = pick;
            m_wd = 0;
        end
        m_err = bus.err_clear ? 1'b0 : (m_err | to);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        bit [N-1:0] eg;
        @(negedge clk);
        if (chk_en) begin
            eg = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            chk("grant", 32'(bus.grant), 32'(eg));
            chk("owner_idx", 32'(bus.owner_idx), 32'(m_last));
            chk("busy", 32'(bus.busy), 32'(m_owner >= 0 || m_drain));
            chk("cmd", 32'({bus.spi_read_trigger, bus.neuron_reset_trigger, bus.turn_off_inference,
                            bus.ext_inference_enable, bus.reg_reset}), 32'(m_cmd));
            chk("g_neuron_idle", 32'(bus.g_neuron_idle), 32'(bus.neuron_idle ? eg : '0));
            chk("g_spi_valid", 32'(bus.g_spi_valid), 32'(bus.spi_valid ? eg : '0));
            chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
            chk("timeout_idx", 32'(bus.timeout_idx), 32'(m_tidx));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int idx, output int n);
        idx = -1;
        for (n = 0; n < 64; n++) begin
            if (bus.grant != 0) break;
            tick();
        end
        chk("grant_seen", 32'(bus.grant != 0), 32'd1);
        for (int i = 0; i < N; i++) if (bus.grant[i]) idx = i;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 64; n++) begin
            if (!bus.busy) break;
            tick();
        end
        chk("idle_reached", 32'(bus.busy), 32'd0);
    endtask

    function automatic logic [4:0] cmd_out();
        return {bus.spi_read_trigger, bus.neuron_reset_trigger, bus.turn_off_inference,
                bus.ext_inference_enable, bus.reg_reset};
    endfunction

    initial begin
        int idx;
        int n;
        int c;
        int exp_ord[4] = '{0, 1, 3, 2};
        bus.req = '0;
        bus.r_spi_read_trigger = '0;
        bus.r_neuron_reset_trigger = '0;
        bus.r_turn_off_inference = '0;
        bus.r_ext_inference_enable = '0;
        bus.r_reg_reset = '0;
        bus.neuron_idle = 1'b1;
        bus.spi_valid = 1'b0;
        bus.err_clear = 1'b0;
        repeat (3) tick();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_cmd", 32'(cmd_out()), 32'd0);
        rst = 1'b0;

        // single requester
        bus.req = 4'b0010;
        tick();
        chk("t1_grant", 32'(bus.grant), 32'b0010);
        chk("t1_owner", 32'(bus.owner_idx), 32'd1);
        repeat (4) tick();
        bus.r_spi_read_trigger = 4'b0010;
        tick();
        bus.r_spi_read_trigger = '0;
        chk("t1_spi_trig", 32'(bus.spi_read_trigger), 32'd1);
        bus.spi_valid = 1'b1;
        #1;
        chk("t1_g_spi_valid", 32'(bus.g_spi_valid), 32'b0010);
        bus.spi_valid = 1'b0;
        tick();
        chk("t1_spi_trig_end", 32'(bus.spi_read_trigger), 32'd0);
        bus.req = '0;
        wait_idle();

        // simultaneous requests from pointer 0, late requester 2, non-owner isolation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            wait_grant(idx, n);
            chk("t2_order", 32'(idx), 32'(exp_ord[k]));
            if (k > 0) chk("t2_guard_gap", 32'(n >= GC), 32'd1);
            if (k == 0) begin
                for (int j = 0; j < 6; j++) begin
                    bus.r_spi_read_trigger     = (j % 2 == 0) ? 4'b0100 : 4'b0000;
                    bus.r_neuron_reset_trigger = bus.r_spi_read_trigger;
                    bus.r_turn_off_inference   = bus.r_spi_read_trigger;
                    bus.r_ext_inference_enable = bus.r_spi_read_trigger;
                    bus.r_reg_reset            = bus.r_spi_read_trigger;
                    tick();
                    chk("t3_isolation", 32'(cmd_out()), 32'd0);
                end
                bus.r_spi_read_trigger = '0;
                bus.r_neuron_reset_trigger = '0;
                bus.r_turn_off_inference = '0;
                bus.r_ext_inference_enable = '0;
                bus.r_reg_reset = '0;
            end
            if (k == 2) bus.req[2] = 1'b1;
            repeat (2) tick();
            if (idx >= 0) bus.req[idx] = 1'b0;
            tick();
        end
        wait_idle();

        // watchdog revoke and lockout
        bus.req = 4'b1000;
        wait_grant(idx, n);
        chk("t4_owner", 32'(idx), 32'd3);
        c = 0;
        while (bus.grant != 0 && c < 100) begin
            c++;
            tick();
        end
        chk("t4_wd_cycles", 32'(c), 32'(TO));
        chk("t4_err", 32'(bus.timeout_err), 32'd1);
        chk("t4_idx", 32'(bus.timeout_idx), 32'd3);
        c = 0;
        repeat (30) begin
            tick();
            if (bus.grant != 0) c++;
        end
        chk("t4_no_regrant", 32'(c), 32'd0);
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        chk("t4_err_clear", 32'(bus.timeout_err), 32'd0);
        bus.req = '0;
        repeat (2) tick();
        bus.req = 4'b1000;
        wait_grant(idx, n);
        chk("t4_regrant", 32'(idx), 32'd3);
        bus.req = '0;
        wait_idle();

        // drain held by neuron_idle=0
        bus.req = 4'b0001;
        wait_grant(idx, n);
        chk("t5_owner", 32'(idx), 32'd0);
        tick();
        bus.neuron_idle = 1'b0;
        bus.req = '0;
        repeat (10) begin
            tick();
            chk("t5_drain_busy", 32'(bus.busy), 32'd1);
        end
        bus.neuron_idle = 1'b1;
        bus.req = 4'b0010;
        tick();
        chk("t5_exit_busy", 32'(bus.busy), 32'd0);
        chk("t5_exit_grant", 32'(bus.grant), 32'd0);
        tick();
        chk("t5_next_grant", 32'(bus.grant), 32'b0010);

        // reset mid-transaction
        bus.r_turn_off_inference = 4'b0010;
        tick();
        chk("t6_toff", 32'(bus.turn_off_inference), 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_rst_grant", 32'(bus.grant), 32'd0);
        chk("t6_rst_toff", 32'(bus.turn_off_inference), 32'd0);
        chk("t6_rst_busy", 32'(bus.busy), 32'd0);
        chk("t6_rst_owner", 32'(bus.owner_idx), 32'd0);
        rst = 1'b0;
        bus.r_turn_off_inference = '0;
        bus.req = 4'b1001;
        tick();
        chk("t6_ptr_zero", 32'(bus.grant), 32'b0001);
        bus.req = '0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/neuron_ctrl_arbiter.md
Name: neuron_ctrl_arbiter

Overview:
- Shares the single neuron-control interface (neuron reset trigger, SPI read trigger, inference-mode controls, register reset) between up to NUM_REQ readout FSMs, e.g. the multi-level output FSM, the binary-output FSM and the partial-sum FSM.
- Uses round-robin arbitration with a grant held for a whole transaction, a guard/drain phase between owners, and a per-grant watchdog that revokes a hung owner.
- Sits between the readout FSMs and the Neurram control module.

Parameters:
NUM_REQ, 4, number of requesting FSMs (2..8)
TIMEOUT_W, 16, width of the watchdog counter
TIMEOUT_CYCLES, 16'hFFFF, watchdog limit in clk cycles; 0 disables the watchdog
GUARD_CYCLES, 4, minimum drain cycles between owners (1..15)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request, level; held for the whole transaction
grant  output  NUM_REQ  one-hot grant, registered
owner_idx  output  3  index of current/last owner
busy  output  1  high in GRANT or DRAIN
r_spi_read_trigger  input  NUM_REQ  per-requester command bits
r_neuron_reset_trigger  input  NUM_REQ  per-requester command bits
r_turn_off_inference  input  NUM_REQ  per-requester command bits
r_ext_inference_enable  input  NUM_REQ  per-requester command bits
r_reg_reset  input  NUM_REQ  per-requester command bits
spi_read_trigger  output  1  to control module, registered
neuron_reset_trigger  output  1  to control module, registered
turn_off_inference  output  1  to control module, registered
ext_inference_enable  output  1  to control module, registered
reg_reset  output  1  to control module, registered
neuron_idle  input  1  from control module
spi_valid  input  1  from control module
g_neuron_idle  output  NUM_REQ  neuron_idle routed to owner only; 0 elsewhere; combinational
g_spi_valid  output  NUM_REQ  spi_valid routed to owner only; 0 elsewhere; combinational
timeout_err  output  1  sticky; set on watchdog revoke
timeout_idx  output  3  owner index at last revoke
err_clear  input  1  clears timeout_err

Behaviour:
- Reset:
  - All outputs 0; state IDLE; round-robin pointer 0; watchdog 0.
  - All masked bits cleared.
  - Reset mid-transaction drops grant and all command outputs on the next edge. No drain phase.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - If any unmasked req is high, pick the first set bit searching from the pointer upward with wrap.
  - Register the one-hot grant and owner_idx; go to GRANT.
  - grant rises 1 cycle after req is sampled.
  - Simultaneous requests resolve in the same cycle; exactly one grant.
- GRANT:
  - Each command output equals the owner's command bit registered (1-cycle latency).
  - Non-owners' command bits are ignored.
  - g_neuron_idle[owner] = neuron_idle and g_spi_valid[owner] = spi_valid, same cycle.
- Release:
  - When req[owner] = 0, grant clears next edge and state goes to DRAIN.
  - pointer = owner+1 mod NUM_REQ.
- Watchdog:
  - Counts every GRANT cycle.
  - Cleared whenever the owner's r_spi_read_trigger or r_neuron_reset_trigger is high.
  - On reaching TIMEOUT_CYCLES (nonzero): grant is revoked, timeout_err=1, timeout_idx=owner, and the owner's mask bit is set; go to DRAIN.
  - The mask bit clears when that req goes low. A revoked requester cannot be re-granted until it drops req.
  - Release and timeout in the same cycle: treated as a normal release; no error.
- DRAIN:
  - All command outputs are 0, so inference returns to the on state (turn_off_inference=0, ext_inference_enable=0).
  - Lasts at least GUARD_CYCLES and until neuron_idle=1, then IDLE.
  - Requests are ignored during DRAIN (stay pending).
- err_clear takes priority over a simultaneous new timeout: the error is cleared, then set next cycle if still timing out.
- busy = (state != IDLE).

Test Plan:
- Single requester: req[1]=1 at cycle 0 → grant=4'b0010 at cycle 1; r_spi_read_trigger[1] pulse at cycle 5 → spi_read_trigger high at cycle 6. spi_valid=1 → g_spi_valid=4'b0010 and other bits 0.
- Simultaneous requests: req=4'b1011 with pointer 0 → grants in order 0, 1, 3, each separated by ≥4 DRAIN cycles. Requester 2 asserts later → served after 3.
- Non-owner isolation: owner 0 idle while requester 2 toggles all command bits → all five command outputs stay 0.
- Watchdog: TIMEOUT_CYCLES=20, owner 3 holds req with no triggers → revoke at 20 GRANT cycles; timeout_err=1, timeout_idx=3. req[3] held high → never re-granted until it drops. err_clear → timeout_err=0.
- Drain gating: release while neuron_idle=0 for 10 cycles → stays in DRAIN 10 cycles; next grant 1 cycle after exit.
- Reset mid-GRANT with turn_off_inference=1 → next edge all outputs 0, grant=0, pointer 0.
